// File: rtl/alu_seq_pkg.sv
// Shared encodings for the multi-byte ALU sequencer: command ops, ALU op codes,
// FSM states and flag bit positions.
package alu_seq_pkg;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_ADC  = 3'd2;
   localparam logic [2:0] OP_SBC  = 3'd3;
   localparam logic [2:0] OP_AND  = 3'd4;
   localparam logic [2:0] OP_OR   = 3'd5;
   localparam logic [2:0] OP_XOR  = 3'd6;
   localparam logic [2:0] OP_PASS = 3'd7;

   // {k,i,j,c_in}; the low bit is the carry-in slot for the arithmetic codes
   localparam logic [3:0] ALUOP_ADD  = 4'b0100;
   localparam logic [3:0] ALUOP_SUB  = 4'b0111;
   localparam logic [3:0] ALUOP_AND  = 4'b1110;
   localparam logic [3:0] ALUOP_OR   = 4'b1010;
   localparam logic [3:0] ALUOP_XOR  = 4'b1000;
   localparam logic [3:0] ALUOP_PASS = 4'b0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int FLAG_C = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_V = 0;

   // Arithmetic ops occupy codes 0..3; odd codes among them subtract.
   function automatic logic op_is_arith(input logic [2:0] op);
      return ~op[2];
   endfunction

   function automatic logic op_is_sub(input logic [2:0] op);
      return ~op[2] & op[0];
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Command, result and ALU-side bus of the sequencer. slave is the sequencer's
// view, master the decode stage's view, alu the external 8-bit ALU's view.
interface alu_seq_if #(
   parameter int NBYTES = 2
);
   localparam int W = 8 * NBYTES;

   logic         cmd_valid;
   logic         cmd_ready;
   logic [2:0]   cmd_op;
   logic [W-1:0] cmd_a;
   logic [W-1:0] cmd_b;
   logic         cmd_cin;

   logic [7:0]   alu_a;
   logic [7:0]   alu_b;
   logic [3:0]   alu_op;
   logic [7:0]   alu_r;
   logic         alu_c;

   logic         res_valid;
   logic         res_ready;
   logic [W-1:0] res_data;
   logic [3:0]   res_flags;

   modport slave (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cin, res_ready, alu_r, alu_c,
      output cmd_ready, res_valid, res_data, res_flags, alu_a, alu_b, alu_op
   );

   modport master (
      output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cin, res_ready,
      input  cmd_ready, res_valid, res_data, res_flags
   );

   modport alu (
      input  alu_a, alu_b, alu_op,
      output alu_r, alu_c
   );

endinterface

// File: rtl/alu_seq_opdec.sv
// Op decoder: maps the running op and chained carry onto the ALU op code, and
// yields the initial carry for a command being accepted.
module alu_seq_opdec
   import alu_seq_pkg::*;
(
   input  logic [2:0] run_op,
   input  logic       cy,
   input  logic [2:0] new_op,
   input  logic       new_cin,
   output logic [3:0] alu_op,
   output logic       arith,
   output logic       sub,
   output logic       init_cy
);

   always_comb begin
      alu_op = ALUOP_PASS;
      case (run_op)
         OP_ADD, OP_ADC: alu_op = {ALUOP_ADD[3:1], cy};
         OP_SUB, OP_SBC: alu_op = {ALUOP_SUB[3:1], cy};
         OP_AND:         alu_op = ALUOP_AND;
         OP_OR:          alu_op = ALUOP_OR;
         OP_XOR:         alu_op = ALUOP_XOR;
         default:        alu_op = ALUOP_PASS;
      endcase
   end

   assign arith = op_is_arith(run_op);
   assign sub   = op_is_sub(run_op);

   // Plain SUB is A + ~B + 1; the carry-taking forms start from the caller's carry.
   always_comb begin
      init_cy = 1'b0;
      case (new_op)
         OP_SUB:         init_cy = 1'b1;
         OP_ADC, OP_SBC: init_cy = new_cin;
         default:        init_cy = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_seq.sv
// Multi-byte ALU sequencer: feeds an external 8-bit ALU one byte per cycle,
// LSB first, chaining carry. Optional macro ALU_SEQ_BACK2BACK_EN lets a new
// command be accepted on the same edge the previous result is consumed.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int NBYTES = 2
) (
   input  logic     clk,
   input  logic     rst_n,
   alu_seq_if.slave bus
);

   localparam int W  = 8 * NBYTES;
   localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

   state_e          state;
   logic [IW-1:0]   idx;
   logic            cy;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic [2:0]      op_q;
   logic [W-1:0]    res_data;
   logic [3:0]      res_flags;
   logic            res_valid;

   logic            cmd_ready;
   logic            accept;
   logic            run;
   logic [3:0]      dec_op;
   logic            arith;
   logic            sub;
   logic            init_cy;
   logic [7:0]      a_byte;
   logic [7:0]      b_byte;
   logic [W-1:0]    res_next;
   logic            beff_msb;
   logic [3:0]      flags_next;

   alu_seq_opdec u_opdec (
      .run_op  (op_q),
      .cy      (cy),
      .new_op  (bus.cmd_op),
      .new_cin (bus.cmd_cin),
      .alu_op  (dec_op),
      .arith   (arith),
      .sub     (sub),
      .init_cy (init_cy)
   );

   always_comb begin
`ifdef ALU_SEQ_BACK2BACK_EN
      cmd_ready = (state == ST_IDLE) | ((state == ST_DONE) & bus.res_ready);
`else
      cmd_ready = (state == ST_IDLE);
`endif
   end

   assign accept = bus.cmd_valid & cmd_ready;
   assign run    = (state == ST_RUN);

   assign a_byte = a_q[idx*8 +: 8];
   assign b_byte = b_q[idx*8 +: 8];

   assign bus.alu_a  = run ? a_byte : 8'h00;
   assign bus.alu_b  = run ? b_byte : 8'h00;
   assign bus.alu_op = run ? dec_op : 4'h0;

   // Result as it will look once the current byte lands; flags are taken from
   // this on the final byte so they are ready the cycle DONE is entered.
   always_comb begin
      res_next = res_data;
      res_next[idx*8 +: 8] = bus.alu_r;
   end

   assign beff_msb = sub ? ~b_q[W-1] : b_q[W-1];

   always_comb begin
      flags_next         = 4'h0;
      flags_next[FLAG_C] = arith & bus.alu_c;
      flags_next[FLAG_Z] = (res_next == '0);
      flags_next[FLAG_N] = res_next[W-1];
      flags_next[FLAG_V] = arith & (a_q[W-1] == beff_msb) & (res_next[W-1] != a_q[W-1]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         idx       <= '0;
         cy        <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= OP_ADD;
         res_data  <= '0;
         res_flags <= 4'h0;
         res_valid <= 1'b0;
      end else if (accept) begin
         // Reached from IDLE, or from DONE while the result is being taken.
         state     <= ST_RUN;
         idx       <= '0;
         cy        <= init_cy;
         a_q       <= bus.cmd_a;
         b_q       <= bus.cmd_b;
         op_q      <= bus.cmd_op;
         res_valid <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               res_data <= res_next;
               cy       <= arith & bus.alu_c;
               if (idx == LAST) begin
                  state     <= ST_DONE;
                  res_flags <= flags_next;
                  res_valid <= 1'b1;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            ST_DONE: begin
               if (bus.res_ready) begin
                  state     <= ST_IDLE;
                  res_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.cmd_ready = cmd_ready;
   assign bus.res_valid = res_valid;
   assign bus.res_data  = res_data;
   assign bus.res_flags = res_flags;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (NBYTES=2) with a behavioural 8-bit ALU attached; directed
// vector table, backpressure and mid-run reset sequences, then random commands.
module tb_alu_seq;
   import alu_seq_pkg::*;

   localparam int NB = 2;
   localparam int W  = 8 * NB;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   alu_seq_if #(.NBYTES(NB)) bus();

   alu_seq #(.NBYTES(NB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Team 8-bit ALU, {k,i,j,c_in}: 01jc = A + (j ? ~B : B) + c
   logic [8:0] sum;
   always_comb begin
      sum       = '0;
      bus.alu_r = 8'h00;
      bus.alu_c = 1'b0;
      if (bus.alu_op[3:2] == 2'b01) begin
         sum       = {1'b0, bus.alu_a} + {1'b0, (bus.alu_op[1] ? ~bus.alu_b : bus.alu_b)}
                     + {8'h00, bus.alu_op[0]};
         bus.alu_r = sum[7:0];
         bus.alu_c = sum[8];
      end else begin
         case (bus.alu_op[3:1])
            3'b111:  bus.alu_r = bus.alu_a & bus.alu_b;
            3'b101:  bus.alu_r = bus.alu_a | bus.alu_b;
            3'b100:  bus.alu_r = bus.alu_a ^ bus.alu_b;
            default: bus.alu_r = bus.alu_a;
         endcase
      end
   end

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] r;
      logic [3:0]   f;
      logic [3:0]   o0;
      logic [3:0]   o1;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Whole-word integer arithmetic; C for subtraction means "no borrow".
   function automatic void ref_model(input logic [2:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b, input logic cin,
                                     output logic [W-1:0] r, output logic [3:0] f);
      int ua, ub, sa, sb, u, s, k;
      logic c, v;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      c  = 1'b0;
      v  = 1'b0;
      r  = '0;
      case (op)
         OP_ADD, OP_ADC: begin
            k = (op == OP_ADC) ? int'(cin) : 0;
            u = ua + ub + k;
            s = sa + sb + k;
            c = (u > 65535);
            v = (s > 32767) || (s < -32768);
            r = u[W-1:0];
         end
         OP_SUB, OP_SBC: begin
            k = (op == OP_SBC) ? 1 - int'(cin) : 0;
            u = ua - ub - k;
            s = sa - sb - k;
            c = (u >= 0);
            v = (s > 32767) || (s < -32768);
            r = u[W-1:0];
         end
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         default: r = a;
      endcase
      f = {c, (r == '0), r[W-1], v};
   endfunction

   task automatic issue(input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic cin);
      int n;
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_a     = a;
      bus.cmd_b     = b;
      bus.cmd_cin   = cin;
      n = 0;
      while (!bus.cmd_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: cmd_ready never rose");
      end
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
   endtask

   // Called just after the accepting edge; returns on the negedge where res_valid is seen.
   task automatic wait_result(output int lat, output logic [3:0] o0, output logic [3:0] o1);
      bit got;
      got = 0;
      lat = 0;
      o0  = 4'h0;
      o1  = 4'h0;
      while (!got && lat < 40) begin
         @(negedge clk);
         if (bus.res_valid) got = 1;
         else begin
            if (lat == 0) o0 = bus.alu_op;
            if (lat == 1) o1 = bus.alu_op;
            @(posedge clk);
            lat++;
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL result_timeout: res_valid never rose");
      end
   endtask

   task automatic handshake(input logic [W-1:0] exp_r);
      bus.res_ready = 1'b1;
      @(posedge clk);
      #1 bus.res_ready = 1'b0;
      @(negedge clk);
      chk("valid_drop", {31'd0, bus.res_valid}, 32'd0);
      chk("data_kept", {16'd0, bus.res_data}, {16'd0, exp_r});
   endtask

   initial begin
      int          lat;
      logic [3:0]  o0, o1;
      logic [W-1:0] er, hold_r;
      logic [3:0]  ef, hold_f;

      bus.cmd_valid = 1'b0;
      bus.cmd_op    = OP_ADD;
      bus.cmd_a     = '0;
      bus.cmd_b     = '0;
      bus.cmd_cin   = 1'b0;
      bus.res_ready = 1'b0;

      tbl[0]  = '{OP_ADD,  16'h00FF, 16'h0001, 1'b0, 16'h0100, 4'b0000, 4'b0100, 4'b0101};
      tbl[1]  = '{OP_SUB,  16'h0000, 16'h0001, 1'b0, 16'hFFFF, 4'b0010, 4'b0111, 4'b0110};
      tbl[2]  = '{OP_ADD,  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b0011, 4'b0100, 4'b0101};
      tbl[3]  = '{OP_ADC,  16'hFFFF, 16'h0000, 1'b1, 16'h0000, 4'b1100, 4'b0101, 4'b0101};
      tbl[4]  = '{OP_XOR,  16'hA5A5, 16'hA5A5, 1'b0, 16'h0000, 4'b0100, 4'b1000, 4'b1000};
      tbl[5]  = '{OP_AND,  16'hF0F0, 16'h0FF0, 1'b0, 16'h00F0, 4'b0000, 4'b1110, 4'b1110};
      tbl[6]  = '{OP_OR,   16'h8000, 16'h0001, 1'b0, 16'h8001, 4'b0010, 4'b1010, 4'b1010};
      tbl[7]  = '{OP_PASS, 16'h1234, 16'hFFFF, 1'b1, 16'h1234, 4'b0000, 4'b0000, 4'b0000};
      tbl[8]  = '{OP_SBC,  16'h0005, 16'h0003, 1'b0, 16'h0001, 4'b1000, 4'b0110, 4'b0111};
      tbl[9]  = '{OP_SUB,  16'h8000, 16'h0001, 1'b0, 16'h7FFF, 4'b1001, 4'b0111, 4'b0110};
      tbl[10] = '{OP_SBC,  16'h0000, 16'h0000, 1'b1, 16'h0000, 4'b1100, 4'b0111, 4'b0111};
      tbl[11] = '{OP_ADD,  16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 4'b1010, 4'b0100, 4'b0101};

      // Reset state
      #2;
      chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
      chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
      chk("rst_alu_op",    {28'd0, bus.alu_op},    32'd0);
      chk("rst_res_data",  {16'd0, bus.res_data},  32'd0);
      chk("rst_res_flags", {28'd0, bus.res_flags}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors
      for (int i = 0; i < 12; i++) begin
         issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cin);
         wait_result(lat, o0, o1);
         chk($sformatf("v%0d_latency", i), lat, 32'd2);
         chk($sformatf("v%0d_op0", i), {28'd0, o0}, {28'd0, tbl[i].o0});
         chk($sformatf("v%0d_op1", i), {28'd0, o1}, {28'd0, tbl[i].o1});
         chk($sformatf("v%0d_data", i), {16'd0, bus.res_data}, {16'd0, tbl[i].r});
         chk($sformatf("v%0d_flags", i), {28'd0, bus.res_flags}, {28'd0, tbl[i].f});
         handshake(tbl[i].r);
      end

      // Backpressure: result held, second command stalls
      issue(OP_ADD, 16'h1234, 16'h0101, 1'b0);
      wait_result(lat, o0, o1);
      hold_r = 16'h1335;
      hold_f = 4'b0000;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = OP_SUB;
      bus.cmd_a     = 16'h5000;
      bus.cmd_b     = 16'h0001;
      bus.cmd_cin   = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_data",      {16'd0, bus.res_data},  {16'd0, hold_r});
         chk("bp_flags",     {28'd0, bus.res_flags}, {28'd0, hold_f});
         chk("bp_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
         chk("bp_res_valid", {31'd0, bus.res_valid}, 32'd1);
      end
      bus.res_ready = 1'b1;
`ifdef ALU_SEQ_BACK2BACK_EN
      #1 chk("b2b_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
      bus.res_ready = 1'b0;
`else
      @(posedge clk);
      #1 bus.res_ready = 1'b0;
      @(negedge clk);
      chk("bp_idle_ready", {31'd0, bus.cmd_ready}, 32'd1);
      chk("bp_idle_valid", {31'd0, bus.res_valid}, 32'd0);
      chk("bp_idle_aluop", {28'd0, bus.alu_op},    32'd0);
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
`endif
      wait_result(lat, o0, o1);
      chk("bp2_latency", lat, 32'd2);
      chk("bp2_op0",   {28'd0, o0}, {28'd0, ALUOP_SUB});
      chk("bp2_data",  {16'd0, bus.res_data},  32'h4FFF);
      chk("bp2_flags", {28'd0, bus.res_flags}, 32'b1000);
      handshake(16'h4FFF);

      // Reset after byte 0 of a carrying add
      issue(OP_ADD, 16'h1234, 16'h00FF, 1'b0);
      @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_res_valid", {31'd0, bus.res_valid}, 32'd0);
      chk("mrst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
      chk("mrst_alu_op",    {28'd0, bus.alu_op},    32'd0);
      chk("mrst_res_data",  {16'd0, bus.res_data},  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      issue(OP_ADD, 16'h0001, 16'h0001, 1'b0);
      wait_result(lat, o0, o1);
      chk("mrst_next_op0",   {28'd0, o0}, {28'd0, ALUOP_ADD});
      chk("mrst_next_data",  {16'd0, bus.res_data},  32'h0002);
      chk("mrst_next_flags", {28'd0, bus.res_flags}, 32'd0);
      handshake(16'h0002);

      // Random commands against the reference model
      for (int i = 0; i < 40; i++) begin
         logic [2:0]   op;
         logic [W-1:0] a, b;
         logic         cin;
         int           d;
         op  = 3'($urandom_range(0, 7));
         a   = W'($urandom);
         b   = W'($urandom);
         cin = 1'($urandom_range(0, 1));
         if (i % 8 == 0) a = 16'h8000;
         if (i % 8 == 1) b = 16'hFFFF;
         ref_model(op, a, b, cin, er, ef);
         issue(op, a, b, cin);
         wait_result(lat, o0, o1);
         chk($sformatf("rnd%0d_latency", i), lat, 32'd2);
         d = $urandom_range(0, 2);
         repeat (d) @(negedge clk);
         chk($sformatf("rnd%0d_data op=%0d a=%h b=%h c=%0d", i, op, a, b, cin),
             {16'd0, bus.res_data}, {16'd0, er});
         chk($sformatf("rnd%0d_flags op=%0d a=%h b=%h c=%0d", i, op, a, b, cin),
             {28'd0, bus.res_flags}, {28'd0, ef});
         handshake(er);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
